// File: rtl/mem_burst_ctrl_if.sv
// Bus between the panel logic (master) and the burst controller (slave),
// including the controller's RAM port.
interface mem_burst_ctrl_if #(
  parameter int M_WIDTH   = 8,
  parameter int M_DEPTH   = 8192,
  parameter int MAX_BURST = 16
);
  localparam int AW = $clog2(M_DEPTH);
  localparam int LW = $clog2(MAX_BURST);

  // Handshakes: a command (cmd_*) or write beat (wr_data) transfers on a rising
  // edge where both valid and ready are high; valid may be held with stable
  // payload until then. rd_valid is a one-cycle strobe with no ready.
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_wr;
  logic [AW-1:0]      cmd_addr;
  logic [LW-1:0]      cmd_len;
  logic [M_WIDTH-1:0] wr_data;
  logic               wr_valid;
  logic               wr_ready;
  logic [M_WIDTH-1:0] rd_data;
  logic               rd_valid;
  logic               done;
  logic [M_WIDTH-1:0] mem_out;
  logic [M_WIDTH-1:0] mem_in;
  logic               mem_w_nr;
  logic [AW-1:0]      mem_addr;
  logic [2:0]         fsm_state;

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_data, wr_valid, mem_out,
    output cmd_ready, wr_ready, rd_data, rd_valid, done, mem_in, mem_w_nr,
           mem_addr, fsm_state
  );

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_data, wr_valid, mem_out,
    input  cmd_ready, wr_ready, rd_data, rd_valid, done, mem_in, mem_w_nr,
           mem_addr, fsm_state
  );
endinterface

// File: rtl/mem_burst_ctrl.sv
// Single-port SRAM burst controller: variable-length read/write bursts with a
// configurable RAM read latency and address wrap modulo M_DEPTH.
module mem_burst_ctrl #(
  parameter int M_WIDTH   = 8,
  parameter int M_DEPTH   = 8192,
  parameter int MAX_BURST = 16,
  parameter int RD_LAT    = 2
) (
  input  logic             clk,
  input  logic             rst,
  mem_burst_ctrl_if.slave  bus
);
  localparam int AW = $clog2(M_DEPTH);
  localparam int LW = $clog2(MAX_BURST);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Pattern of the in-flight shift register when only the final beat remains.
  localparam logic [RD_LAT-1:0] VLD_TOP = RD_LAT'(1) << (RD_LAT - 1);

  logic [2:0]         state;
  logic [LW-1:0]      len_q;
  logic [LW-1:0]      cnt;
  logic [AW-1:0]      ptr;
  logic [RD_LAT-1:0]  vld_sr;
  logic               issue;

  logic [AW-1:0]      mem_addr_q;
  logic [M_WIDTH-1:0] mem_in_q;
  logic               mem_w_nr_q;
  logic [M_WIDTH-1:0] rd_data_q;
  logic               rd_valid_q;
  logic               done_q;

  // Explicit compare keeps the wrap correct for non-power-of-two depths.
  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    if (a == AW'(M_DEPTH - 1)) return '0;
    else return a + AW'(1);
  endfunction

  assign issue = ((state == S_IDLE) && bus.cmd_valid && !bus.cmd_wr) ||
                 (state == S_READ);

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.wr_ready  = (state == S_WRITE);
  assign bus.fsm_state = state;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_in    = mem_in_q;
  assign bus.mem_w_nr  = mem_w_nr_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.done      = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      len_q      <= '0;
      cnt        <= '0;
      ptr        <= '0;
      vld_sr     <= '0;
      mem_addr_q <= '0;
      mem_in_q   <= '0;
      mem_w_nr_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      vld_sr[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) vld_sr[i] <= vld_sr[i-1];
      rd_valid_q <= vld_sr[RD_LAT-1];
      if (vld_sr[RD_LAT-1]) rd_data_q <= bus.mem_out;
      done_q     <= 1'b0;
      mem_w_nr_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            len_q <= bus.cmd_len;
            cnt   <= '0;
            ptr   <= bus.cmd_addr;
            if (!bus.cmd_wr) begin
              mem_addr_q <= bus.cmd_addr;
              // A single-beat read has already issued its only address.
              state <= (bus.cmd_len == '0) ? S_DRAIN : S_READ;
            end else begin
              state <= S_WRITE;
            end
          end
        end
        S_READ: begin
          mem_addr_q <= addr_inc(mem_addr_q);
          cnt        <= cnt + LW'(1);
          if (cnt == len_q - LW'(1)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (vld_sr == VLD_TOP) begin
            done_q <= 1'b1;
            state  <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (bus.wr_valid) begin
            mem_addr_q <= ptr;
            ptr        <= addr_inc(ptr);
            mem_in_q   <= bus.wr_data;
            mem_w_nr_q <= 1'b1;
            cnt        <= cnt + LW'(1);
            if (cnt == len_q) state <= S_DONE;
          end
        end
        S_DONE: begin
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl: two instances (read latency 2 and 1),
// behavioural RAM models, event logs and a read-data expected queue.
module tb_mem_burst_ctrl;
  localparam int MW = 8;
  localparam int MD = 8192;
  localparam int MB = 16;
  localparam int AW = $clog2(MD);
  localparam int LW = $clog2(MB);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_burst_ctrl_if #(.M_WIDTH(MW), .M_DEPTH(MD), .MAX_BURST(MB)) bus0 ();
  mem_burst_ctrl_if #(.M_WIDTH(MW), .M_DEPTH(MD), .MAX_BURST(MB)) bus1 ();

  mem_burst_ctrl #(.M_WIDTH(MW), .M_DEPTH(MD), .MAX_BURST(MB), .RD_LAT(2)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  mem_burst_ctrl #(.M_WIDTH(MW), .M_DEPTH(MD), .MAX_BURST(MB), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  // RAM models: dut0 sees one registered stage, dut1 a combinational read.
  logic [MW-1:0] mem0 [0:MD-1];
  logic [MW-1:0] mem1 [0:MD-1];
  logic [MW-1:0] mem0_q = '0;
  always @(posedge clk) begin
    if (bus0.mem_w_nr) mem0[bus0.mem_addr] <= bus0.mem_in;
    mem0_q <= mem0[bus0.mem_addr];
  end
  assign bus0.mem_out = mem0_q;
  assign bus1.mem_out = mem1[bus1.mem_addr];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err = 0;
  logic [MW-1:0] exp0_q[$];
  logic [MW-1:0] exp1_q[$];
  int rd0_cyc[$], rd1_cyc[$], done0_cyc[$], done1_cyc[$];
  int wr_cyc[$], wr_addr[$];
  logic [MW-1:0] wr_dat[$];
  logic [MW-1:0] wdata_q[$];
  bit pat_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.rd_valid) begin
        rd0_cyc.push_back(cyc);
        if (exp0_q.size() == 0) check("rd0_unexpected", 32'(bus0.rd_valid), 0);
        else check("rd0_data", 32'(bus0.rd_data), 32'(exp0_q.pop_front()));
      end
      if (bus0.done) done0_cyc.push_back(cyc);
      if (bus0.mem_w_nr) begin
        wr_cyc.push_back(cyc);
        wr_addr.push_back(int'(bus0.mem_addr));
        wr_dat.push_back(bus0.mem_in);
      end
      if (bus1.rd_valid) begin
        rd1_cyc.push_back(cyc);
        if (exp1_q.size() == 0) check("rd1_unexpected", 32'(bus1.rd_valid), 0);
        else check("rd1_data", 32'(bus1.rd_data), 32'(exp1_q.pop_front()));
      end
      if (bus1.done) done1_cyc.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    rd0_cyc.delete(); rd1_cyc.delete(); done0_cyc.delete(); done1_cyc.delete();
    wr_cyc.delete(); wr_addr.delete(); wr_dat.delete();
  endtask

  task automatic drive_cmd(input int sel, input bit wr, input int addr, input int len);
    if (sel == 0) begin
      bus0.cmd_valid = 1'b1; bus0.cmd_wr = wr;
      bus0.cmd_addr = AW'(addr); bus0.cmd_len = LW'(len);
    end else begin
      bus1.cmd_valid = 1'b1; bus1.cmd_wr = wr;
      bus1.cmd_addr = AW'(addr); bus1.cmd_len = LW'(len);
    end
  endtask

  task automatic release_cmd(input int sel);
    if (sel == 0) bus0.cmd_valid = 1'b0;
    else bus1.cmd_valid = 1'b0;
  endtask

  // Returns the index of the accepting edge, then leaves time 1 past it.
  task automatic wait_accept(input int sel, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if ((sel == 0) ? bus0.cmd_ready : bus1.cmd_ready) begin
        @(posedge clk);
        acc = cyc;
        #1;
        got = 1'b1;
      end
    end
    check("accept_timeout", 32'(got), 1);
  endtask

  task automatic wait_done(input int sel, input int max_cyc);
    bit got;
    got = 1'b0;
    for (int k = 0; k < max_cyc && !got; k++) begin
      @(negedge clk);
      if ((sel == 0) ? bus0.done : bus1.done) got = 1'b1;
    end
    check("done_timeout", 32'(got), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic read_burst(input int sel, input int addr, input int len, output int acc);
    clear_logs();
    drive_cmd(sel, 1'b0, addr, len);
    wait_accept(sel, acc);
    release_cmd(sel);
    wait_done(sel, 80);
  endtask

  task automatic write_burst(input int addr, input int len, output int acc);
    int idx;
    clear_logs();
    drive_cmd(0, 1'b1, addr, len);
    wait_accept(0, acc);
    release_cmd(0);
    idx = 0;
    foreach (pat_q[k]) begin
      bus0.wr_valid = pat_q[k];
      bus0.wr_data  = pat_q[k] ? wdata_q[idx] : '0;
      if (pat_q[k]) idx++;
      @(posedge clk);
      #1;
    end
    bus0.wr_valid = 1'b0;
    wait_done(0, 20);
  endtask

  task automatic check_idle_outputs();
    check("rst_cmd_ready", 32'(bus0.cmd_ready), 1);
    check("rst_wr_ready", 32'(bus0.wr_ready), 0);
    check("rst_rd_valid", 32'(bus0.rd_valid), 0);
    check("rst_done", 32'(bus0.done), 0);
    check("rst_mem_w_nr", 32'(bus0.mem_w_nr), 0);
    check("rst_mem_addr", 32'(bus0.mem_addr), 0);
    check("rst_mem_in", 32'(bus0.mem_in), 0);
    check("rst_rd_data", 32'(bus0.rd_data), 0);
  endtask

  task automatic check_wr(input int acc, input int base, input int n, input bit btb);
    check("wr_count", wr_cyc.size(), n);
    for (int i = 0; i < n && i < wr_cyc.size(); i++) begin
      check("wr_addr", wr_addr[i], (base + i) % MD);
      check("wr_data", 32'(wr_dat[i]), 32'(wdata_q[i]));
      if (btb) check("wr_cyc", wr_cyc[i], acc + 2 + i);
    end
  endtask

  task automatic check_done0(input int exp_cyc);
    check("done_count", done0_cyc.size(), 1);
    if (done0_cyc.size() > 0) check("done_cyc", done0_cyc[0], exp_cyc);
  endtask

  // Beat i appears lat+1+i cycles after acceptance; done lands with the last beat.
  task automatic check_rd(input int sel, input int acc, input int n, input int lat);
    int q[$];
    int d[$];
    if (sel == 0) begin q = rd0_cyc; d = done0_cyc; end
    else begin q = rd1_cyc; d = done1_cyc; end
    check("rd_count", q.size(), n);
    for (int i = 0; i < n && i < q.size(); i++) check("rd_cyc", q[i], acc + lat + 1 + i);
    check("rd_done_count", d.size(), 1);
    if (d.size() > 0) check("rd_done_cyc", d[0], acc + lat + n);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int acc, a1, a2;
    bus0.cmd_valid = 0; bus0.cmd_wr = 0; bus0.cmd_addr = '0; bus0.cmd_len = '0;
    bus0.wr_valid = 0; bus0.wr_data = '0;
    bus1.cmd_valid = 0; bus1.cmd_wr = 0; bus1.cmd_addr = '0; bus1.cmd_len = '0;
    bus1.wr_valid = 0; bus1.wr_data = '0;
    for (int i = 0; i < MD; i++) begin mem0[i] = '0; mem1[i] = '0; end
    for (int i = 0; i < 16; i++) mem1[32 + i] = MW'(8'h50 + i);

    #1 rst = 1'b1;
    @(negedge clk);
    check_idle_outputs();
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back write burst
    wdata_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    pat_q = '{1, 1, 1, 1};
    write_burst(16, 3, acc);
    check_wr(acc, 16, 4, 1);
    check_done0(acc + 6);

    // Read it back
    exp0_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    read_burst(0, 16, 3, acc);
    check_rd(0, acc, 4, 2);

    // Address wrap at the top of memory
    wdata_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    pat_q = '{1, 1, 1, 1};
    write_burst(8190, 3, acc);
    check_wr(acc, 8190, 4, 1);
    exp0_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    read_burst(0, 8190, 3, acc);
    check_rd(0, acc, 4, 2);

    // Write beats with gaps
    wdata_q = '{8'h5A, 8'h6B, 8'h7C};
    pat_q = '{1, 0, 0, 1, 0, 1};
    write_burst(64, 2, acc);
    check_wr(acc, 64, 3, 0);
    if (wr_cyc.size() >= 3) begin
      check("gap_cyc0", wr_cyc[0], acc + 2);
      check("gap_cyc1", wr_cyc[1], acc + 5);
      check("gap_cyc2", wr_cyc[2], acc + 7);
    end
    check_done0(acc + 8);

    // Reset in the middle of an 8-beat read
    clear_logs();
    drive_cmd(0, 1'b0, 16, 7);
    wait_accept(0, acc);
    release_cmd(0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check_idle_outputs();
    #3 rst = 1'b0;
    @(negedge clk);
    check("rst_release_cmd_ready", 32'(bus0.cmd_ready), 1);
    repeat (12) @(negedge clk);
    check("rst_no_rd_valid", rd0_cyc.size(), 0);
    check("rst_no_done", done0_cyc.size(), 0);
    @(posedge clk); #1;

    // Full-length write and read
    wdata_q.delete();
    pat_q.delete();
    for (int i = 0; i < 16; i++) begin wdata_q.push_back(MW'(i * 3 + 1)); pat_q.push_back(1); end
    write_burst(256, 15, acc);
    check_wr(acc, 256, 16, 1);
    check_done0(acc + 18);
    for (int i = 0; i < 16; i++) exp0_q.push_back(MW'(i * 3 + 1));
    read_burst(0, 256, 15, acc);
    check_rd(0, acc, 16, 2);

    // Single-beat read
    exp0_q = '{8'hB2};
    read_burst(0, 17, 0, acc);
    check_rd(0, acc, 1, 2);

    // Command held while busy: second one waits for IDLE
    clear_logs();
    exp0_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hC3};
    drive_cmd(0, 1'b0, 16, 3);
    wait_accept(0, a1);
    drive_cmd(0, 1'b0, 18, 0);
    @(negedge clk);
    check("busy_cmd_ready", 32'(bus0.cmd_ready), 0);
    wait_accept(0, a2);
    release_cmd(0);
    wait_done(0, 40);
    check("busy_accept_gap", a2 - a1, 6);
    check("busy_rd_count", rd0_cyc.size(), 5);
    if (rd0_cyc.size() >= 5) check("busy_rd2_cyc", rd0_cyc[4], a2 + 3);
    check("busy_done_count", done0_cyc.size(), 2);

    // Read latency 1 instance
    exp1_q = '{8'h50};
    read_burst(1, 32, 0, acc);
    check_rd(1, acc, 1, 1);
    for (int i = 0; i < 16; i++) exp1_q.push_back(MW'(8'h50 + i));
    read_burst(1, 32, 15, acc);
    check_rd(1, acc, 16, 1);

    repeat (4) @(negedge clk);
    check("exp0_drained", exp0_q.size(), 0);
    check("exp1_drained", exp1_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_burst_ctrl.md
Name: mem_burst_ctrl

Overview:
Parametrised single-port SRAM controller that runs variable-length read and write bursts of 1..MAX_BURST words.
- Commands arrive on a valid/ready handshake; write data streams in with valid/ready; read data streams out with a valid strobe.
- Handles a configurable memory read latency and wraps addresses modulo M_DEPTH.
- Sits between the panel logic and the on-chip frame/state RAM, replacing fixed 1/2-word access sequences.

Parameters:
M_WIDTH, 8, memory word width in bits
M_DEPTH, 8192, memory depth in words; AW = $clog2(M_DEPTH)
MAX_BURST, 16, maximum burst length; power of two, >=2; LW = $clog2(MAX_BURST)
RD_LAT, 2, clock edges from a mem_addr update to the matching mem_out being sampled; >=1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  controller can accept a command
cmd_wr  in  1  1 = write burst, 0 = read burst
cmd_addr  in  AW  burst start address
cmd_len  in  LW  burst length minus 1
wr_data  in  M_WIDTH  write beat data
wr_valid  in  1  write beat valid
wr_ready  out  1  controller accepts a write beat
rd_data  out  M_WIDTH  read beat data
rd_valid  out  1  rd_data valid, one cycle per beat, no backpressure
done  out  1  one-cycle burst-complete pulse
mem_out  in  M_WIDTH  RAM read data
mem_in  out  M_WIDTH  RAM write data
mem_w_nr  out  1  RAM write enable (1 = write, 0 = read)
mem_addr  out  AW  RAM address

Behaviour:
- Reset (asynchronous, any state): state IDLE; mem_addr, mem_in, rd_data = 0; mem_w_nr, rd_valid, done = 0; beat counters cleared; in-flight reads discarded, so no rd_valid follows reset.
- States:
  - IDLE: cmd_ready = 1. On cmd_valid, the command is accepted at that edge E0. cmd_addr and cmd_len are latched. Next state is READ if cmd_wr = 0, otherwise WRITE.
  - READ: mem_addr <= cmd_addr at E0, then address+1 on each following edge, for len+1 addresses in total. mem_w_nr stays 0. After the last address is issued, go to DRAIN.
    - Beat i is sampled at edge E0+i+RD_LAT. It is presented on rd_data with rd_valid = 1 for exactly one cycle, so beats are back-to-back.
    - A shift register of issue-valid bits, RD_LAT deep, tracks in-flight beats.
  - DRAIN: wait until the last beat's rd_valid. done = 1 in the same cycle as the last rd_valid. Then go to IDLE.
  - WRITE: wr_ready = 1. On an edge with wr_valid = 1:
    - mem_addr <= next address; mem_in <= wr_data; mem_w_nr <= 1; beat count +1.
    - On an edge without wr_valid: mem_w_nr <= 0, and address and count hold. Gaps are allowed with no timeout.
    - After beat len is accepted, go to DONE.
  - DONE: mem_w_nr <= 0; done = 1 for one cycle; wr_ready = 0; next state IDLE.
- Ready signals: cmd_ready = 0 in every state except IDLE. cmd_valid is ignored while busy and is not queued. wr_data/wr_valid are ignored outside WRITE.
- Address arithmetic: modulo M_DEPTH (AW-bit wrap). For non-power-of-two M_DEPTH, M_DEPTH-1 + 1 -> 0.
- cmd_len = 0 gives a single-beat burst.
- Minimum turnaround is one IDLE cycle between bursts.
- All outputs are registered, except cmd_ready and wr_ready, which decode from state.

Test Plan:
1. Reset values: assert rst mid-idle -> all outputs 0, cmd_ready = 1. Assert rst during a READ at beat 2 of 8 -> rd_valid never asserts afterwards; cmd_ready = 1 the cycle after release.
2. Write burst: addr 0x010, len 3, data A1,B2,C3,D4 presented back-to-back -> four consecutive mem_w_nr = 1 cycles at addresses 0x010..0x013 with matching mem_in; done one cycle after the last strobe; mem_w_nr = 0 in the done cycle+1.
3. Read back the same burst with RD_LAT = 2 -> rd_valid high for 4 consecutive cycles starting 3 cycles after cmd acceptance, data A1,B2,C3,D4; done coincident with D4.
4. Wrap: write then read at addr 8190, len 3 -> addresses 8190, 8191, 0, 1; data intact.
5. Write gaps: wr_valid pattern 1,0,0,1,0,1 for len 2 -> exactly 3 strobes at consecutive addresses; mem_w_nr = 0 during gap cycles.
6. Busy rejection and length edge cases: cmd_valid held during a burst -> second command accepted only after returning to IDLE. Single beat (len 0) and full MAX_BURST = 16 read -> 1 and 16 rd_valid pulses respectively. Repeat with RD_LAT = 1 -> first rd_valid 2 cycles after acceptance.
